exhaustive_stim_capture: RTL
============================

# exhaustive_stim_capture

Synthesizable stimulus/response harness for the trojan-detection benchmark flow. It walks every input pattern of a small combinational or sequential DUT in ascending order and holds each pattern for a programmable settle time. It then samples the DUT response and queues {pattern, response} pairs in a response buffer that a downstream logger drains over a valid/ready handshake. It replaces fixed-width, fixed-timing bench sequencing with a parametrised, stall-safe engine that has an optional signature compactor.

## Interface
- N_IN, 2: DUT input width; patterns 0 .. 2^N_IN-1 (1..16).
- N_OUT, 1: DUT response width (1..16).
- SETTLE, 1: cycles each pattern is held before sampling (≥1).
- DEPTH, 4: response buffer entries (power of 2, ≥2).
- CK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin a sweep; sampled only in IDLE.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse after the last pattern is captured.
- stim  out  N_IN  pattern driven to the DUT.
- resp  in  N_OUT  DUT response.
- rd_valid  out  1  buffer non-empty.
- rd_ready  in  1  consumer accepts head entry.
- rd_pattern  out  N_IN  pattern of head entry.
- rd_resp  out  N_OUT  response of head entry.
- sig  out  16  MISR signature (see Configuration).

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE: busy=0, stim holds its last value. start=1 at an edge → APPLY with stim=0, settle counter=0.
- APPLY: busy=1, stim constant. Counter increments each cycle up to SETTLE-1. On the edge ending the cycle where counter=SETTLE-1, {stim, resp} is pushed if a push is permitted.
  - On push, if stim≠all-ones: stim increments, counter→0, stay in APPLY.
  - On push, if stim=all-ones: → DONE.
  - If the push is not permitted (stall): counter holds at SETTLE-1, stim holds, retry every cycle. No entry is ever lost or duplicated.
- DONE: done=1 and busy=1 for exactly one cycle, then → IDLE.
- Push permitted: buffer count<DEPTH, or count=DEPTH with a pop in the same cycle.
- Pop: rd_valid & rd_ready at an edge. The head advances and count decrements, or stays unchanged on a simultaneous push.
- Buffer pointers wrap modulo DEPTH. rd_pattern/rd_resp show the head entry combinationally from storage. Their value is don't-care when rd_valid=0.
- start while busy is ignored.
- The buffer drains independently of the FSM. Entries from a finished sweep remain readable after the next start.

## Timing
- Reset (reset=0, asynchronous):
  - FSM→IDLE; stim=0, busy=0, done=0.
  - Buffer emptied, so rd_valid=0.
  - sig=16'h0000.
  - Takes effect immediately, including mid-sweep. The partial sweep is discarded and no done pulse is produced.
- start seen at edge E0 → busy=1 and stim=0 from E0. Pattern k is captured at edge E0+(k+1)·SETTLE with no stalls.
- done is high in the cycle after the final capture edge. For an unstalled sweep that is cycle E0+2^N_IN·SETTLE.
- Push-to-rd_valid latency: 1 edge (entry visible after the capture edge).
- resp must be stable SETTLE cycles after stim changes. The block adds no resynchronisation.

## Configuration
- SIG_MISR_EN defined:
  - On every push: sig ← (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended resp.
  - sig clears to 0 on start-accept as well as on reset.
- SIG_MISR_EN undefined: sig is tied to 16'h0000 and no MISR register is synthesized.

## Test plan
- Basic sweep:
  - Setup: N_IN=2, N_OUT=1, SETTLE=1, DEPTH=4; resp=stim[0]&stim[1]; rd_ready=0.
  - Stimulus: start pulse at E0.
  - Required: buffer holds (00,0),(01,0),(10,0),(11,1); done pulses in cycle E0+4.
  - Then rd_ready=1: 4 pops in that order; rd_valid=0 afterwards.
- Stall on full:
  - Setup: DEPTH=2, rd_ready=0.
  - Required: stim holds 2'b10 indefinitely, busy=1, done=0.
  - Then one pop: 10 is captured next edge and stim→11. No pattern is lost across the full run.
- Settle:
  - Setup: SETTLE=3; resp driven through a 2-cycle register delay from stim.
  - Required: captured responses match the zero-delay case; done at E0+12.
- MISR (SIG_MISR_EN on):
  - Stimulus: basic-sweep stimulus.
  - Required: sig=16'h0001 after done.
  - Second sweep with resp=~stim[0]: sig recomputed from 0 per the polynomial.
- Reset mid-run:
  - Stimulus: assert reset=0 asynchronously while stim=01 and 1 entry is queued.
  - Required: stim=0, busy=0, rd_valid=0, sig=0 immediately; no done pulse.
  - After release, a new start runs a full sweep.
- start while busy:
  - Stimulus: pulse start mid-sweep.
  - Required: no restart, stim sequence uninterrupted, exactly one done.

Source files
------------

// File: rtl/exhaustive_stim_capture.sv
// Exhaustive pattern sweep engine: applies every N_IN-bit pattern, samples the DUT response
// after SETTLE cycles and queues {pattern, response} for a logger. Optional MISR via SIG_MISR_EN.
module exhaustive_stim_capture #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] resp,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [N_IN-1:0]  rd_pattern,
    output logic [N_OUT-1:0] rd_resp,
    output logic [15:0]      sig
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [N_IN-1:0]   pat_mem  [DEPTH];
    logic [N_OUT-1:0]  resp_mem [DEPTH];
    logic              start_ok, at_sample, pop, push, last;

    assign start_ok  = (state == S_IDLE) && start;
    assign at_sample = (state == S_APPLY) && (cnt == CW'(SETTLE - 1));
    assign pop       = rd_valid && rd_ready;
    // A full buffer still accepts the capture when the head leaves on the same edge.
    assign push      = at_sample && ((count != (AW+1)'(DEPTH)) || pop);
    assign last      = (stim == '1);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy = 1'b1;
                if (push && last) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Settle counter parks at SETTLE-1 while the buffer is full, so the capture retries.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            stim <= '0;
            cnt  <= '0;
        end else if (start_ok) begin
            stim <= '0;
            cnt  <= '0;
        end else if (state == S_APPLY) begin
            if (!at_sample) begin
                cnt <= cnt + CW'(1);
            end else if (push && !last) begin
                stim <= stim + N_IN'(1);
                cnt  <= '0;
            end
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (push) begin
            pat_mem[wr_ptr]  <= stim;
            resp_mem[wr_ptr] <= resp;
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_pattern = pat_mem[rd_ptr];
    assign rd_resp    = resp_mem[rd_ptr];

`ifdef SIG_MISR_EN
    logic [15:0] sig_r;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset)        sig_r <= 16'h0000;
        else if (start_ok) sig_r <= 16'h0000;
        else if (push)     sig_r <= {sig_r[14:0], 1'b0} ^ (sig_r[15] ? 16'h1021 : 16'h0000) ^ 16'(resp);
    end

    assign sig = sig_r;
`else
    assign sig = 16'h0000;
`endif

endmodule
